// File: rtl/race_position_controller.sv
// ARM-Racer game sequencer: sprite positions, collision detection, scoring and
// the IDLE/RUN/CRASH game state machine. All outputs are registered.
module race_position_controller #(
    parameter int unsigned PLAYER_START = 280,
    parameter int unsigned PLAYER_MIN   = 100,
    parameter int unsigned PLAYER_MAX   = 440,
    parameter int unsigned PLAYER_STEP  = 4,
    parameter int unsigned ENEMY1_START = 0,
    parameter int unsigned ENEMY2_START = 240,
    parameter int unsigned ENEMY_STEP   = 2,
    parameter int unsigned MAX_STEP     = 8,
    parameter int unsigned WRAP_Y       = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    output logic [9:0]  posicion_jugador,
    output logic [9:0]  posicion_enemigo1,
    output logic [9:0]  posicion_enemigo2,
    output logic [1:0]  game_state,
    output logic        collision,
    output logic [15:0] score
);

    localparam int unsigned POS_W      = 10;
    localparam int unsigned CMP_W      = 11;
    localparam int unsigned SCORE_W    = 16;
    localparam int unsigned SPRITE_W   = 100;
    localparam int unsigned SPRITE_H   = 124;
    localparam int unsigned PLAYER_Y   = 340;
    localparam int unsigned ENEMY1_X   = 150;
    localparam int unsigned ENEMY2_X   = 400;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CRASH = 2'b10
    } state_t;

    state_t               state, state_next;
    logic [POS_W-1:0]     pj_q, e1_q, e2_q;
    logic [POS_W-1:0]     pj_next, e1_next, e2_next;
    logic [SCORE_W-1:0]   score_q, score_next;
    logic                 collision_q, collision_next;
    logic                 btn_start_q;
    logic                 start_rise;

    logic [CMP_W-1:0]     pj_w, e1_w, e2_w;
    logic                 hit1, hit2, hit;
    logic [13:0]          step_raw;
    logic [CMP_W-1:0]     step;
    logic [CMP_W-1:0]     e1_sum, e2_sum;
    logic                 e1_wrap, e2_wrap;
    logic [POS_W-1:0]     e1_adv, e2_adv, pj_adv;
    logic [1:0]           wrap_cnt;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_adv;

    assign start_rise = btn_start & ~btn_start_q;

    assign pj_w = {1'b0, pj_q};
    assign e1_w = {1'b0, e1_q};
    assign e2_w = {1'b0, e2_q};

    // Bounding-box overlap of the player against each enemy lane
    assign hit1 = (pj_w < CMP_W'(ENEMY1_X + SPRITE_W))
               && ((pj_w + CMP_W'(SPRITE_W)) > CMP_W'(ENEMY1_X))
               && ((e1_w + CMP_W'(SPRITE_H)) > CMP_W'(PLAYER_Y))
               && (e1_w < CMP_W'(PLAYER_Y + SPRITE_H));
    assign hit2 = (pj_w < CMP_W'(ENEMY2_X + SPRITE_W))
               && ((pj_w + CMP_W'(SPRITE_W)) > CMP_W'(ENEMY2_X))
               && ((e2_w + CMP_W'(SPRITE_H)) > CMP_W'(PLAYER_Y))
               && (e2_w < CMP_W'(PLAYER_Y + SPRITE_H));
    assign hit  = hit1 | hit2;

    // Enemy speed grows by one pixel every eight points, capped
    assign step_raw = 14'(ENEMY_STEP) + 14'(score_q[15:3]);
    assign step     = (step_raw > 14'(MAX_STEP)) ? CMP_W'(MAX_STEP) : CMP_W'(step_raw);

    assign e1_sum   = e1_w + step;
    assign e2_sum   = e2_w + step;
    assign e1_wrap  = (e1_sum >= CMP_W'(WRAP_Y));
    assign e2_wrap  = (e2_sum >= CMP_W'(WRAP_Y));
    assign e1_adv   = e1_wrap ? '0 : e1_sum[POS_W-1:0];
    assign e2_adv   = e2_wrap ? '0 : e2_sum[POS_W-1:0];

    assign wrap_cnt  = {1'b0, e1_wrap} + {1'b0, e2_wrap};
    assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(wrap_cnt);
    assign score_adv = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    // Player X after one frame of button movement, clamped to the road
    always_comb begin
        pj_adv = pj_q;
        if (btn_left && !btn_right) begin
            if (pj_w < CMP_W'(PLAYER_MIN + PLAYER_STEP))
                pj_adv = POS_W'(PLAYER_MIN);
            else
                pj_adv = POS_W'(pj_w - CMP_W'(PLAYER_STEP));
        end else if (btn_right && !btn_left) begin
            if ((pj_w + CMP_W'(PLAYER_STEP)) > CMP_W'(PLAYER_MAX))
                pj_adv = POS_W'(PLAYER_MAX);
            else
                pj_adv = POS_W'(pj_w + CMP_W'(PLAYER_STEP));
        end
    end

    // Game state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_rise) state_next = RUN;
            RUN:     if (hit)        state_next = CRASH;
            CRASH:   if (start_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; hit beats a coincident frame_tick
    always_comb begin
        pj_next        = pj_q;
        e1_next        = e1_q;
        e2_next        = e2_q;
        score_next     = score_q;
        collision_next = collision_q;
        case (state)
            IDLE: begin
                pj_next = POS_W'(PLAYER_START);
                e1_next = POS_W'(ENEMY1_START);
                e2_next = POS_W'(ENEMY2_START);
                if (start_rise) score_next = '0;
            end
            RUN: begin
                if (hit) begin
                    collision_next = 1'b1;
                end else if (frame_tick) begin
                    pj_next    = pj_adv;
                    e1_next    = e1_adv;
                    e2_next    = e2_adv;
                    score_next = score_adv;
                end
            end
            CRASH: begin
                if (start_rise) begin
                    collision_next = 1'b0;
                    pj_next        = POS_W'(PLAYER_START);
                    e1_next        = POS_W'(ENEMY1_START);
                    e2_next        = POS_W'(ENEMY2_START);
                end
            end
            default: begin
                collision_next = 1'b0;
            end
        endcase
    end

    // Output and start-edge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pj_q        <= POS_W'(PLAYER_START);
            e1_q        <= POS_W'(ENEMY1_START);
            e2_q        <= POS_W'(ENEMY2_START);
            score_q     <= '0;
            collision_q <= 1'b0;
            btn_start_q <= 1'b0;
        end else begin
            pj_q        <= pj_next;
            e1_q        <= e1_next;
            e2_q        <= e2_next;
            score_q     <= score_next;
            collision_q <= collision_next;
            btn_start_q <= btn_start;
        end
    end

    assign posicion_jugador  = pj_q;
    assign posicion_enemigo1 = e1_q;
    assign posicion_enemigo2 = e2_q;
    assign game_state        = state;
    assign collision         = collision_q;
    assign score             = score_q;

endmodule

// File: tb/tb_race_position_controller.sv
// Directed testbench for race_position_controller.
module tb_race_position_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_start = 1'b0;
    logic [9:0]  posicion_jugador;
    logic [9:0]  posicion_enemigo1;
    logic [9:0]  posicion_enemigo2;
    logic [1:0]  game_state;
    logic        collision;
    logic [15:0] score;

    int total = 0;
    int bad = 0;

    logic [48:0] obs;
    logic [48:0] exp_v;

    race_position_controller dut (
        .clk               (clk),
        .rst               (rst),
        .frame_tick        (frame_tick),
        .btn_left          (btn_left),
        .btn_right         (btn_right),
        .btn_start         (btn_start),
        .posicion_jugador  (posicion_jugador),
        .posicion_enemigo1 (posicion_enemigo1),
        .posicion_enemigo2 (posicion_enemigo2),
        .game_state        (game_state),
        .collision         (collision),
        .score             (score)
    );

    always #5 clk = ~clk;

    assign obs = {posicion_jugador, posicion_enemigo1, posicion_enemigo2, game_state, collision, score};

    function automatic logic [48:0] pack(input int pj, input int e1, input int e2,
                                         input int st, input int col, input int sc);
        return {10'(pj), 10'(e1), 10'(e2), 2'(st), 1'(col), 16'(sc)};
    endfunction

    function automatic string fmt(input logic [48:0] v);
        return $sformatf("pj=%0d e1=%0d e2=%0d st=%0d col=%0d sc=%0d",
                         v[48:39], v[38:29], v[28:19], v[18:17], v[16], v[15:0]);
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step_clk();
        frame_tick = 1'b0;
        step_clk();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
        step_clk();
        step_clk();
        rst = 1'b0;
    endtask

    task automatic start_game();
        btn_start = 1'b1;
        step_clk();
        btn_start = 1'b0;
        step_clk();
    endtask

    task automatic test_reset();
        do_reset();
        total++; exp_v = pack(280, 0, 240, 0, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL reset got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_left = 1'b1;
        ticks(3);
        btn_left = 1'b0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL idle_ignores_inputs got %s want %s", fmt(obs), fmt(exp_v)); end
    endtask

    task automatic test_start();
        btn_start = 1'b1;
        step_clk();
        total++; exp_v = pack(280, 0, 240, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL start_edge got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_start = 1'b0;
        repeat (3) step_clk();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL run_no_tick got %s want %s", fmt(obs), fmt(exp_v)); end
    endtask

    task automatic test_player_moves();
        btn_left = 1'b1;
        ticks(1);
        total++; exp_v = pack(276, 2, 242, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL left_first_tick got %s want %s", fmt(obs), fmt(exp_v)); end
        ticks(44);
        total++; exp_v = pack(100, 90, 330, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL left_45 got %s want %s", fmt(obs), fmt(exp_v)); end
        ticks(5);
        total++; exp_v = pack(100, 100, 340, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL left_clamp got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_right = 1'b1;
        ticks(3);
        total++; exp_v = pack(100, 106, 346, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL both_held got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_left = 1'b0; btn_right = 1'b0;
        ticks(2);
        total++; exp_v = pack(100, 110, 350, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL none_held got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_start = 1'b1;
        step_clk();
        btn_start = 1'b0;
        step_clk();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL start_ignored_run got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_right = 1'b1;
        ticks(40);
        btn_right = 1'b0;
        total++; exp_v = pack(260, 190, 430, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL right_move got %s want %s", fmt(obs), fmt(exp_v)); end
    endtask

    task automatic test_wrap();
        ticks(24);
        total++; exp_v = pack(260, 238, 478, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL pre_wrap got %s want %s", fmt(obs), fmt(exp_v)); end
        ticks(1);
        total++; exp_v = pack(260, 240, 0, 1, 0, 1);
        if (obs !== exp_v) begin bad++; $display("FAIL wrap_at_480 got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_right = 1'b1;
        ticks(50);
        btn_right = 1'b0;
        total++; exp_v = pack(440, 340, 100, 1, 0, 1);
        if (obs !== exp_v) begin bad++; $display("FAIL right_clamp got %s want %s", fmt(obs), fmt(exp_v)); end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        total++; exp_v = pack(280, 0, 240, 0, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL reset_mid_run got %s want %s", fmt(obs), fmt(exp_v)); end
    endtask

    task automatic test_crash();
        start_game();
        ticks(120);
        total++; exp_v = pack(280, 240, 0, 1, 0, 1);
        if (obs !== exp_v) begin bad++; $display("FAIL crash_setup got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_left = 1'b1;
        ticks(7);
        total++; exp_v = pack(252, 254, 14, 1, 0, 1);
        if (obs !== exp_v) begin bad++; $display("FAIL edge_no_hit got %s want %s", fmt(obs), fmt(exp_v)); end
        frame_tick = 1'b1;
        step_clk();
        total++; exp_v = pack(248, 256, 16, 1, 0, 1);
        if (obs !== exp_v) begin bad++; $display("FAIL hit_position got %s want %s", fmt(obs), fmt(exp_v)); end
        step_clk();
        frame_tick = 1'b0;
        total++; exp_v = pack(248, 256, 16, 2, 1, 1);
        if (obs !== exp_v) begin bad++; $display("FAIL hit_priority got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_left = 1'b0; btn_right = 1'b1;
        ticks(5);
        btn_right = 1'b0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL crash_frozen got %s want %s", fmt(obs), fmt(exp_v)); end
    endtask

    task automatic test_restart();
        btn_start = 1'b1;
        step_clk();
        total++; exp_v = pack(280, 0, 240, 0, 0, 1);
        if (obs !== exp_v) begin bad++; $display("FAIL crash_to_idle got %s want %s", fmt(obs), fmt(exp_v)); end
        tick();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL needs_second_edge got %s want %s", fmt(obs), fmt(exp_v)); end
        btn_start = 1'b0;
        step_clk();
        btn_start = 1'b1;
        step_clk();
        btn_start = 1'b0;
        total++; exp_v = pack(280, 0, 240, 1, 0, 0);
        if (obs !== exp_v) begin bad++; $display("FAIL second_start got %s want %s", fmt(obs), fmt(exp_v)); end
    endtask

    // Long run with the player parked in the safe gap; enemy motion tracked per tick
    task automatic test_step_cap();
        int me1, me2, ms, st, n1, n2, w, guard;
        do_reset();
        start_game();
        me1 = 0; me2 = 240; ms = 0; guard = 0;
        while (ms < 64 && guard < 6000) begin
            st = 2 + ms / 8;
            if (st > 8) st = 8;
            n1 = me1 + st;
            n2 = me2 + st;
            w  = 0;
            if (n1 >= 480) begin me1 = 0; w++; end else me1 = n1;
            if (n2 >= 480) begin me2 = 0; w++; end else me2 = n2;
            ms = ms + w;
            tick();
            guard++;
            if (w != 0) begin
                total++; exp_v = pack(280, me1, me2, 1, 0, ms);
                if (obs !== exp_v) begin bad++; $display("FAIL step_wrap tick=%0d got %s want %s", guard, fmt(obs), fmt(exp_v)); end
            end
        end
        n1 = me1 + 8;
        n2 = me2 + 8;
        me1 = (n1 >= 480) ? 0 : n1;
        me2 = (n2 >= 480) ? 0 : n2;
        if (n1 >= 480) ms++;
        if (n2 >= 480) ms++;
        tick();
        total++; exp_v = pack(280, me1, me2, 1, 0, ms);
        if (obs !== exp_v) begin bad++; $display("FAIL step_capped_8 got %s want %s", fmt(obs), fmt(exp_v)); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_player_moves();
        test_wrap();
        test_reset_mid_run();
        test_crash();
        test_restart();
        test_step_cap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
